// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned DEF_FIFO_WIDTH = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned RETRY_W        = 3;
    localparam int unsigned TOTAL_W        = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        WAIT
    } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer request/grant bus plus FIFO write-side signals.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16
);

    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ*FIFO_WIDTH-1:0]       req_data;
    logic [NUM_REQ-1:0]                  gnt_ack;
    logic [NUM_REQ-1:0]                  gnt_err;
    logic                                fifo_wr_en;
    logic [FIFO_WIDTH-1:0]               fifo_data_in;
    logic                                fifo_full;
    logic                                fifo_wr_ack;
    logic                                fifo_overflow;
    logic                                busy;
    logic [fifo_arb_pkg::TOTAL_W-1:0]    retry_total;

    modport master (
        input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        output gnt_ack, gnt_err, fifo_wr_en, fifo_data_in, busy, retry_total
    );

    modport slave (
        output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
        input  gnt_ack, gnt_err, fifo_wr_en, fifo_data_in, busy, retry_total
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible producer after last_gnt, wrapping.
module fifo_rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               valid_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_gnt) + k) % NUM_REQ);
            if (!valid_c && eligible[cand]) begin
                valid_c = 1'b1;
                idx_c   = cand;
            end
        end
        if (valid_c) begin
            gnt_c = NUM_REQ'(1) << idx_c;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; each write goes grant -> issue -> response,
// with overflowed writes retried until acknowledged or dropped.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int unsigned MAX_RETRY  = 3
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_REQ-1:0]     oh_q, oh_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [FIFO_WIDTH-1:0]  data_q, data_d;
    logic [TOTAL_W-1:0]     total_q, total_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [NUM_REQ-1:0]     err_q, err_d;
    logic                   wr_en_q, wr_en_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     eligible_c;
    logic [NUM_REQ-1:0]     pick_gnt_c;
    logic [IDX_W-1:0]       pick_idx_c;
    logic                   pick_valid_c;
    logic [FIFO_WIDTH-1:0]  words_c [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words_c[i] = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // A producer being acknowledged this cycle is not yet offering a new word.
    assign eligible_c = bus.req & ~ack_q & ~err_q;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible (eligible_c),
        .last_gnt (last_q),
        .gnt_c    (pick_gnt_c),
        .idx_c    (pick_idx_c),
        .valid_c  (pick_valid_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        oh_d    = oh_q;
        retry_d = retry_q;
        data_d  = data_q;
        total_d = total_q;
        ack_d   = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid_c && !bus.fifo_full) begin
                    idx_d   = pick_idx_c;
                    oh_d    = pick_gnt_c;
                    data_d  = words_c[pick_idx_c];
                    retry_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                if (bus.fifo_wr_ack) begin
                    ack_d   = oh_q;
                    last_d  = idx_q;
                    state_d = IDLE;
                end else begin
                    // No acknowledge is handled exactly like an overflow.
                    if (total_q != '1) begin
                        total_d = total_q + TOTAL_W'(1);
                    end
                    if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                        err_d   = oh_q;
                        last_d  = idx_q;
                        state_d = IDLE;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.fifo_full) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en_d = (state_d == ISSUE);
    assign busy_d  = (state_d != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            oh_q    <= '0;
            retry_q <= '0;
            data_q  <= '0;
            total_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            oh_q    <= oh_d;
            retry_q <= retry_d;
            data_q  <= data_d;
            total_q <= total_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt_ack      = ack_q;
    assign bus.gnt_err      = err_q;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_data_in = data_q;
    assign bus.busy         = busy_q;
    assign bus.retry_total  = total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural FIFO, grant-order table, corner sequences, random traffic.
module tb_fifo_wr_arbiter;

    logic clk;
    logic rst;
    logic rd_en;
    int   force_ovf;
    logic [15:0] fifo_q[$];

    int checks;
    int failures;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .FIFO_WIDTH (16),
        .MAX_RETRY  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Depth-8 FIFO with registered ack/overflow; force_ovf rejects the next N writes.
    always @(posedge clk or posedge rst) begin
        logic ack_n, ovf_n;
        if (rst) begin
            fifo_q.delete();
            bus.fifo_wr_ack   <= 1'b0;
            bus.fifo_overflow <= 1'b0;
            bus.fifo_full     <= 1'b0;
        end else begin
            ack_n = 1'b0;
            ovf_n = 1'b0;
            if (bus.fifo_wr_en) begin
                if (force_ovf > 0) begin
                    ovf_n = 1'b1;
                    force_ovf--;
                end else if (fifo_q.size() < 8) begin
                    fifo_q.push_back(bus.fifo_data_in);
                    ack_n = 1'b1;
                end else begin
                    ovf_n = 1'b1;
                end
            end
            if (rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
            bus.fifo_wr_ack   <= ack_n;
            bus.fifo_overflow <= ovf_n;
            bus.fifo_full     <= (fifo_q.size() == 8);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int i);
        if (i < 0) return 4'b0000;
        return 4'(1) << i;
    endfunction

    function automatic logic [15:0] word(input int e, input int i);
        if (e == 0) return 16'hA5A5;
        return 16'(e * 256 + i + 16'h4000);
    endfunction

    function automatic int rr_pick(input logic [3:0] el, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (el[2'(c)]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        force_ovf = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},   32'(bus.gnt_ack), 0);
        check({tag, "_err"},   32'(bus.gnt_err), 0);
        check({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 0);
        check({tag, "_data"},  32'(bus.fifo_data_in), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_total"}, 32'(bus.retry_total), 0);
    endtask

    // Serve one word per masked producer; each grant must follow ord at nominal 3-cycle spacing.
    task automatic serve(input int e, input logic [3:0] mask, input int n, input logic [15:0] ord);
        @(negedge clk);
        for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = word(e, i);
        bus.req = mask;
        for (int g = 0; g < n; g++) begin
            int p, lat;
            logic found;
            p = int'(ord[g*4 +: 4]);
            found = 1'b0;
            lat = 0;
            for (int c = 0; c < 12 && !found; c++) begin
                @(negedge clk);
                lat++;
                if (bus.fifo_wr_en) found = 1'b1;
            end
            check($sformatf("v%0d_g%0d_issue", e, g), 32'(found), 1);
            check($sformatf("v%0d_g%0d_latency", e, g), 32'(lat), 1);
            check($sformatf("v%0d_g%0d_data", e, g), 32'(bus.fifo_data_in), 32'(word(e, p)));
            @(negedge clk);
            check($sformatf("v%0d_g%0d_wr_once", e, g), 32'(bus.fifo_wr_en), 0);
            @(negedge clk);
            check($sformatf("v%0d_g%0d_ack", e, g), 32'(bus.gnt_ack), 32'(onehot(p)));
            check($sformatf("v%0d_g%0d_err", e, g), 32'(bus.gnt_err), 0);
            bus.req[2'(p)] = 1'b0;
        end
    endtask

    task automatic run_retry(input string tag, input int ovf, input int p, input logic [15:0] d,
                             input int exp_issues, input logic exp_ack, input int exp_total);
        int issues, ovfs;
        logic done;
        logic [3:0] ackv, errv;
        do_reset();
        rd_en = 1'b0;
        force_ovf = ovf;
        bus.req_data[p*16 +: 16] = d;
        bus.req = onehot(p);
        issues = 0; ovfs = 0; done = 1'b0; ackv = '0; errv = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (bus.fifo_wr_en) begin
                issues++;
                check({tag, "_issue_data"}, 32'(bus.fifo_data_in), 32'(d));
            end
            if (bus.fifo_overflow) ovfs++;
            if (bus.gnt_ack != 0) begin ackv = bus.gnt_ack; done = 1'b1; end
            if (bus.gnt_err != 0) begin errv = bus.gnt_err; done = 1'b1; end
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_issues"}, 32'(issues), 32'(exp_issues));
        check({tag, "_overflows"}, 32'(ovfs), 32'(ovf));
        check({tag, "_ack"}, 32'(ackv), exp_ack ? 32'(onehot(p)) : 0);
        check({tag, "_err"}, 32'(errv), exp_ack ? 0 : 32'(onehot(p)));
        check({tag, "_total"}, 32'(bus.retry_total), 32'(exp_total));
        bus.req = '0;
    endtask

    typedef struct {
        logic        do_rst;
        logic [3:0]  mask;
        int          n;
        logic [15:0] ord;
        int          exp_cnt;
    } vec_t;

    vec_t tbl [7];

    logic [15:0] pbuf [4][64];
    int head [4];
    int tail [4];

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        rd_en = 1'b0;
        force_ovf = 0;
        bus.req = '0;
        bus.req_data = '0;

        // Grant order follows round-robin from the previous winner (reset leaves producer 3 as last).
        tbl[0] = '{1'b1, 4'b0100, 1, 16'h0002, 1};
        tbl[1] = '{1'b1, 4'b1111, 4, 16'h3210, 4};
        tbl[2] = '{1'b0, 4'b1010, 2, 16'h0031, -1};
        tbl[3] = '{1'b0, 4'b0101, 2, 16'h0020, -1};
        tbl[4] = '{1'b0, 4'b1001, 2, 16'h0003, -1};
        tbl[5] = '{1'b0, 4'b0110, 2, 16'h0021, -1};
        tbl[6] = '{1'b0, 4'b1111, 4, 16'h2103, -1};

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_reset");

        for (int e = 0; e < 7; e++) begin
            if (tbl[e].do_rst) do_reset();
            if (e == 2) rd_en = 1'b1;
            serve(e, tbl[e].mask, tbl[e].n, tbl[e].ord);
            if (tbl[e].exp_cnt >= 0) begin
                check($sformatf("v%0d_fifo_count", e), 32'(fifo_q.size()), 32'(tbl[e].exp_cnt));
                for (int g = 0; g < tbl[e].n && g < fifo_q.size(); g++) begin
                    logic [15:0] o;
                    o = tbl[e].ord;
                    check($sformatf("v%0d_fifo_word%0d", e, g), 32'(fifo_q[g]), 32'(word(e, int'(o[g*4 +: 4]))));
                end
            end
        end

        // Full FIFO holds the arbiter in IDLE until a read frees a slot.
        begin
            logic seen, found;
            do_reset();
            rd_en = 1'b0;
            for (int k = 0; k < 8; k++) fifo_q.push_back(16'(k));
            @(negedge clk);
            bus.req_data[16 +: 16] = 16'h7777;
            bus.req = 4'b0010;
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                seen |= bus.fifo_wr_en;
            end
            check("full_no_write", 32'(seen), 0);
            check("full_idle", 32'(bus.busy), 0);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            found = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 12 && !found; c++) begin
                @(negedge clk);
                if (bus.fifo_wr_en) seen = (bus.fifo_data_in == 16'h7777);
                if (bus.gnt_ack != 0) found = 1'b1;
            end
            check("full_ack_seen", 32'(found), 1);
            check("full_ack_idx", 32'(bus.gnt_ack), 32'(4'b0010));
            check("full_write_data", 32'(seen), 1);
            bus.req = '0;
        end

        run_retry("ovf3", 3, 0, 16'hBEEF, 3, 1'b0, 3);
        run_retry("ovf1", 1, 2, 16'h1234, 2, 1'b1, 1);

        // Reset in RESP aborts silently; producer 0 then wins first again.
        begin
            logic seen, found;
            do_reset();
            bus.req_data[16 +: 16] = 16'h5A5A;
            bus.req = 4'b0010;
            @(negedge clk);
            check("rstmid_issue", 32'(bus.fifo_wr_en), 1);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check_zero("rstmid");
            seen = 1'b0;
            repeat (2) begin
                @(negedge clk);
                seen |= (bus.gnt_ack != 0) || (bus.gnt_err != 0);
            end
            check("rstmid_no_pulse", 32'(seen), 0);
            rst = 1'b0;
            bus.req_data[15:0] = 16'h0F0F;
            bus.req = 4'b0011;
            found = 1'b0;
            for (int c = 0; c < 12 && !found; c++) begin
                @(negedge clk);
                if (bus.fifo_wr_en) found = 1'b1;
            end
            check("rstmid_regrant", 32'(found), 1);
            check("rstmid_p0_first", 32'(bus.fifo_data_in), 32'(16'h0F0F));
        end

        // Random traffic against a transaction-level round-robin model.
        begin
            int last, inflight, added, acks, writes;
            logic [3:0] prev_req, prev_ack;
            logic done;
            do_reset();
            for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
            last = 3; inflight = -1; added = 0; acks = 0; writes = 0;
            prev_req = '0; prev_ack = '0; done = 1'b0;
            for (int n = 0; n < 4000 && !done; n++) begin
                @(negedge clk);
                if (bus.fifo_wr_en) begin
                    int w;
                    w = rr_pick(prev_req & ~prev_ack, last);
                    check("rand_winner_exists", 32'(w >= 0), 1);
                    if (w >= 0) begin
                        check("rand_data", 32'(bus.fifo_data_in), 32'(pbuf[w][head[w]]));
                        last = w;
                    end
                    inflight = w;
                    writes++;
                end
                if (bus.gnt_ack != 0) begin
                    check("rand_ack", 32'(bus.gnt_ack), 32'(onehot(inflight)));
                    if (inflight >= 0) head[inflight]++;
                    acks++;
                end
                if (bus.gnt_err != 0) check("rand_err", 32'(bus.gnt_err), 0);
                prev_ack = bus.gnt_ack;
                if (added < 48 && $urandom_range(0, 2) == 0) begin
                    int p;
                    p = int'($urandom_range(0, 3));
                    pbuf[p][tail[p]] = 16'($urandom);
                    tail[p]++;
                    added++;
                end
                for (int i = 0; i < 4; i++) begin
                    bus.req[2'(i)] = (head[i] < tail[i]);
                    bus.req_data[i*16 +: 16] = (head[i] < tail[i]) ? pbuf[i][head[i]] : 16'h0;
                end
                prev_req = bus.req;
                rd_en = 1'($urandom_range(0, 1));
                if (added == 48 && bus.req == 0 && !bus.busy && bus.gnt_ack == 0) done = 1'b1;
            end
            check("rand_done", 32'(done), 1);
            check("rand_writes", 32'(writes), 48);
            check("rand_acks", 32'(acks), 48);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the synchronous FIFO (FIFO_WIDTH 16, FIFO_DEPTH 8) among NUM_REQ producers. It sits between the producers and the FIFO write side, and it sequences every write as grant, issue, then response. Each write is confirmed on the FIFO's registered wr_ack. Writes rejected with overflow are retried until they succeed or are dropped.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (2..8)
- FIFO_WIDTH, 16, data width; matches the FIFO
- MAX_RETRY, 3, overflow retries before a write is dropped (1..7)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-producer write request; held until gnt_ack or gnt_err
- req_data  in  NUM_REQ*FIFO_WIDTH  producer i data in slice [i*FIFO_WIDTH +: FIFO_WIDTH]
- gnt_ack  out  NUM_REQ  one-cycle pulse: producer's word accepted by the FIFO
- gnt_err  out  NUM_REQ  one-cycle pulse: word dropped after MAX_RETRY overflows
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  FIFO_WIDTH  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_wr_ack  in  1  FIFO write acknowledge, registered, valid one cycle after wr_en
- fifo_overflow  in  1  FIFO overflow, registered, valid one cycle after wr_en
- busy  out  1  state != IDLE
- retry_total  out  8  saturating count of overflow retries since reset

## Operation
- States: IDLE, ISSUE, RESP, WAIT.
- IDLE
  - Form eligible = req & ~gnt_ack & ~gnt_err, masking a producer that is acknowledged this cycle.
  - If eligible != 0 and !fifo_full: select the winner by round-robin starting at last_gnt+1, wrapping modulo NUM_REQ.
  - Latch the winner's index and data, clear retry, go to ISSUE.
- ISSUE
  - fifo_wr_en=1 for exactly this cycle; fifo_data_in = latched data.
  - Go to RESP.
- RESP
  - fifo_wr_ack=1: set gnt_ack[idx] next cycle, last_gnt<=idx, go to IDLE.
  - Otherwise (overflow, or neither flag set, treated as overflow):
    - Increment retry_total, saturating at 255.
    - If retry==MAX_RETRY-1: set gnt_err[idx] next cycle, last_gnt<=idx, go to IDLE.
    - Else retry++, go to WAIT.
- WAIT: when !fifo_full, go to ISSUE with the same latched data; otherwise stay.
- Outputs are registered and state-decoded. fifo_data_in holds the latched value and is 0 after reset.
- Deasserting req after grant does not cancel the transaction; ack or err still pulses.
- Exactly one of gnt_ack/gnt_err pulses per grant, one bit at a time, never simultaneous.
- Simultaneous requests are granted strictly in round-robin order. A producer holding req is served within NUM_REQ grants.

## Timing
- Reset (async assert, sync-safe deassert):
  - State IDLE; last_gnt=NUM_REQ-1, so producer 0 wins first; retry=0.
  - gnt_ack=0, gnt_err=0, fifo_wr_en=0, fifo_data_in=0, busy=0, retry_total=0.
- Reset mid-transaction aborts the transaction with no ack/err pulse.
- Nominal latency, with req sampled in IDLE at cycle 0:
  - cycle 1: fifo_wr_en=1
  - cycle 2: RESP samples wr_ack
  - cycle 3: gnt_ack pulse, and IDLE evaluates the next grant
- Throughput: one write per 3 cycles.
- Each retry adds ISSUE+RESP (2 cycles), plus WAIT cycles while fifo_full=1.
- Producers must drop req in the gnt_ack/gnt_err cycle or hold it for a new word. The arbiter masks req in that cycle, so it never double-writes.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, ISSUE, RESP, WAIT), FIFO_WIDTH/FIFO_DEPTH defaults, RETRY_W=3.
- Sub-module fifo_rr_pick: combinational round-robin selector.
  - Inputs: eligible vector, last_gnt.
  - Outputs: one-hot grant, index, valid.
- Top module holds the FSM, latches, counters and output registers.

## Test plan
- Single producer after reset: req[2]=1, data 16'hA5A5, FIFO empty.
  - Required: fifo_wr_en at cycle 1 with A5A5, gnt_ack[2] at cycle 3, FIFO count 1.
- All four producers request simultaneously from reset.
  - Required: grants in order 0,1,2,3; four gnt_ack pulses 3 cycles apart; data order preserved in the FIFO.
- FIFO pre-filled to 8, then req[1]=1.
  - Required: arbiter stays IDLE with fifo_wr_en=0.
  - After one read (full drops): write is issued and gnt_ack[1] pulses.
- Forced fifo_overflow on 3 consecutive responses.
  - Required: three ISSUE pulses, gnt_err[idx] pulse, retry_total=3, no gnt_ack.
- Overflow once, then wr_ack.
  - Required: second ISSUE carries identical data, gnt_ack pulses, retry_total increments by 1.
- rst=1 asserted during RESP.
  - Required: all outputs 0 immediately, no ack/err pulse.
  - After release, producer 0 has priority.
